// File: rtl/uart_rx_pkg.sv
// Shared widths, legal oversampling ratios and the effective-prescale helper
// for the UART receiver bit timer.
package uart_rx_pkg;

    localparam int EDGE_W = 5;
    localparam int BIT_W  = 3;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    function automatic logic prescale_legal(input logic [5:0] prescale);
        return (prescale == PRESCALE_8) || (prescale == PRESCALE_16) ||
               (prescale == PRESCALE_32);
    endfunction

    // Unsupported ratios fall back to the smallest legal one so the counters stay bounded.
    function automatic logic [5:0] eff_prescale(input logic [5:0] prescale);
        return prescale_legal(prescale) ? prescale : PRESCALE_8;
    endfunction

endpackage

// File: rtl/rx_sync_ff.sv
// Flop-chain synchronizer for the serial line; every stage resets to the
// idle level 1 so no false start edge is seen after reset.
module rx_sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // NOTE: sequential state is written with <= only, so every flop samples the pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            chain <= '1;
        end else begin
            chain <= (chain << 1) | SYNC_STAGES'(d);
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_bit_timer.sv
// UART receiver front end: oversampling edge counter, data-bit counter and
// 3-sample majority vote. Optional RX_IN synchronizer under `UART_RX_SYNC_EN.
module uart_rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic [5:0]        Prescale,
    input  logic              enable,
    input  logic              dat_samp_en,
    input  logic              reset_count,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              sampled_bit,
    output logic              sample_valid,
    output logic              prescale_err
);

    logic              rx_s;
    logic [5:0]        prescale_q;
    logic [5:0]        ep;
    logic [EDGE_W-1:0] edge_last;
    logic [EDGE_W-1:0] mid;
    logic [EDGE_W-1:0] mid_m1;
    logic [EDGE_W-1:0] mid_p1;
    logic              wrap;
    logic              s0;
    logic              s1;
    logic              vote;

`ifdef UART_RX_SYNC_EN
    rx_sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx_sync (
        .CLK(CLK),
        .RST(RST),
        .d  (RX_IN),
        .q  (rx_s)
    );
`else
    assign rx_s = RX_IN;
`endif

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        ep        = eff_prescale(prescale_q);
        edge_last = EDGE_W'(ep - 6'd1);
        mid       = EDGE_W'(ep >> 1);
        mid_m1    = mid - EDGE_W'(1);
        mid_p1    = mid + EDGE_W'(1);
        wrap      = enable && (edge_cnt == edge_last);
        vote      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    end

    // The ratio is only taken while idle or at a bit boundary, so a bit never changes length midway.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prescale_q   <= PRESCALE_8;
            prescale_err <= 1'b0;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
        end else begin
            prescale_err <= !prescale_legal(Prescale);
            if (!enable || wrap) begin
                prescale_q <= Prescale;
            end

            if (!enable || wrap) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + EDGE_W'(1);
            end

            if (reset_count || !enable) begin
                bit_cnt <= '0;
            end else if (wrap) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

    // The vote is not gated by enable so a frame ending right at MID+1 still gets its strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s0           <= 1'b1;
            s1           <= 1'b1;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else begin
            // NOTE: the strobe defaults low each cycle and is raised only by the vote below.
            sample_valid <= 1'b0;

            if (!enable) begin
                s0 <= 1'b1;
                s1 <= 1'b1;
            end else if (dat_samp_en) begin
                if (edge_cnt == mid_m1) s0 <= rx_s;
                if (edge_cnt == mid)    s1 <= rx_s;
            end

            if (dat_samp_en && (edge_cnt == mid_p1)) begin
                sampled_bit  <= vote;
                sample_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Directed bench for uart_rx_bit_timer: expected outputs are queued as each
// step is driven and compared one clock later, 1 time unit after the edge.
module tb_uart_rx_bit_timer;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       enable;
    logic       dat_samp_en;
    logic       reset_count;
    logic [4:0] edge_cnt;
    logic [2:0] bit_cnt;
    logic       sampled_bit;
    logic       sample_valid;
    logic       prescale_err;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string tag;
        int    edge_e;
        int    bit_e;
        logic  samp_e;
        logic  valid_e;
        logic  err_e;
    } exp_t;

    exp_t sb[$];

    uart_rx_bit_timer dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .enable      (enable),
        .dat_samp_en (dat_samp_en),
        .reset_count (reset_count),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .sampled_bit (sampled_bit),
        .sample_valid(sample_valid),
        .prescale_err(prescale_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, "/edge_cnt"},     32'(edge_cnt),     32'(e.edge_e));
            check({e.tag, "/bit_cnt"},      32'(bit_cnt),      32'(e.bit_e));
            check({e.tag, "/sampled_bit"},  32'(sampled_bit),  32'(e.samp_e));
            check({e.tag, "/sample_valid"}, 32'(sample_valid), 32'(e.valid_e));
            check({e.tag, "/prescale_err"}, 32'(prescale_err), 32'(e.err_e));
        end
    endtask

    // Queue what the outputs must be after the next edge, clock once, then compare.
    task automatic step(input string tag, input int e, input int b,
                        input logic s, input logic v, input logic er);
        sb.push_back('{tag, e, b, s, v, er});
        @(posedge CLK);
        #1;
        compare();
    endtask

    initial begin
        RST         = 1'b1;
        RX_IN       = 1'b1;
        Prescale    = 6'd16;
        enable      = 1'b0;
        dat_samp_en = 1'b0;
        reset_count = 1'b0;

        step("reset", 0, 0, 1'b1, 1'b0, 1'b0);
        RST = 1'b0;
        step("idle", 0, 0, 1'b1, 1'b0, 1'b0);

        // Prescale 16: edge 0..15 wrapping, bit_cnt 1 after first wrap, 2 after second.
        enable = 1'b1;
        for (int k = 1; k <= 40; k++)
            step("p16_count", k % 16, k / 16, 1'b1, 1'b0, 1'b0);

        // Prescale 8, line held low: strobe at edge 6 every bit, voted bit 0.
        enable   = 1'b0;
        Prescale = 6'd8;
        RX_IN    = 1'b0;
        step("p8_idle", 0, 0, 1'b1, 1'b0, 1'b0);
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        for (int k = 1; k <= 24; k++)
            step("p8_rx0", k % 8, k / 8, (k >= 6) ? 1'b0 : 1'b1, (k % 8) == 6, 1'b0);

        // Prescale 32, one-cycle low glitch while edge_cnt==16 is outvoted.
        enable   = 1'b0;
        Prescale = 6'd32;
        RX_IN    = 1'b1;
        step("p32_idle", 0, 0, 1'b0, 1'b0, 1'b0);
        enable = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            step("p32_glitch", k, 0, (k >= 18) ? 1'b1 : 1'b0, k == 18, 1'b0);
            if (k == 16) RX_IN = 1'b0;
            if (k == 17) RX_IN = 1'b1;
        end

        // Prescale 16 with reset_count held, then released for eight wraps.
        enable      = 1'b0;
        dat_samp_en = 1'b0;
        Prescale    = 6'd16;
        step("p16_idle", 0, 0, 1'b1, 1'b0, 1'b0);
        enable      = 1'b1;
        reset_count = 1'b1;
        for (int k = 1; k <= 32; k++)
            step("rc_hold", k % 16, 0, 1'b1, 1'b0, 1'b0);
        reset_count = 1'b0;
        for (int k = 33; k <= 160; k++)
            step("rc_free", k % 16, ((k - 32) / 16) % 8, 1'b1, 1'b0, 1'b0);

        // enable drops on the cycle edge_cnt==MID+1: vote still lands.
        enable      = 1'b0;
        Prescale    = 6'd8;
        RX_IN       = 1'b0;
        dat_samp_en = 1'b1;
        step("efall_idle", 0, 0, 1'b1, 1'b0, 1'b0);
        enable = 1'b1;
        for (int k = 1; k <= 5; k++)
            step("efall_run", k, 0, 1'b1, 1'b0, 1'b0);
        enable = 1'b0;
        step("efall_vote", 0, 0, 1'b0, 1'b1, 1'b0);
        step("efall_after", 0, 0, 1'b0, 1'b0, 1'b0);

        // Illegal Prescale 20: error flag set, counters run as Prescale 8.
        dat_samp_en = 1'b0;
        Prescale    = 6'd20;
        step("p20_idle", 0, 0, 1'b0, 1'b0, 1'b1);
        enable = 1'b1;
        for (int k = 1; k <= 17; k++)
            step("p20_count", k % 8, k / 8, 1'b0, 1'b0, 1'b1);

        // Reset in mid-frame at edge_cnt==9 with a vote pending: everything back to reset values.
        enable   = 1'b0;
        Prescale = 6'd16;
        step("p16b_idle", 0, 0, 1'b0, 1'b0, 1'b0);
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        for (int k = 1; k <= 25; k++)
            step("pre_rst", k % 16, k / 16, 1'b0, (k % 16) == 10, 1'b0);
        RST = 1'b1;
        step("mid_rst", 0, 0, 1'b1, 1'b0, 1'b0);
        RST    = 1'b0;
        enable = 1'b0;
        step("post_rst", 0, 0, 1'b1, 1'b0, 1'b0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
